// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit with HI/LO registers.
// MULT/DIV run one bit per cycle on unsigned magnitudes, then a single FIX
// cycle applies signs and writes HI/LO. MFHI/MFLO/MTHI/MTLO are served in IDLE.
module muldiv_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] FnMfhi  = 6'd16;
  localparam logic [5:0] FnMthi  = 6'd17;
  localparam logic [5:0] FnMflo  = 6'd18;
  localparam logic [5:0] FnMtlo  = 6'd19;
  localparam logic [5:0] FnMult  = 6'd24;
  localparam logic [5:0] FnMultu = 6'd25;
  localparam logic [5:0] FnDiv   = 6'd26;
  localparam logic [5:0] FnDivu  = 6'd27;

  localparam int unsigned     CntW     = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_t;

  state_t             state_q;
  // MUL: {partial product, remaining multiplier}. DIV: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [CntW-1:0]    cnt_q;
  logic               is_mul_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               div0_q;

  logic               decoded;
  logic               fn_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // 16..19 and 24..27 are the only functions this unit owns.
  assign decoded   = (func_code[5:2] == 4'b0100) || (func_code[5:2] == 4'b0110);
  assign stall     = valid & busy & decoded;
  assign fn_signed = SIGNED_EN && ((func_code == FnMult) || (func_code == FnDiv));
  assign mag_a     = (fn_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b     = (fn_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // Shift-add step: add multiplicand to the upper half when the multiplier LSB is set.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring step: shift in the next dividend bit and try to subtract the divisor.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  // Sign fix-up applied in FIX.
  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quot_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Control FSM, iteration datapath and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      opnd_q       <= '0;
      dividend_q   <= '0;
      cnt_q        <= '0;
      is_mul_q     <= 1'b0;
      neg_q        <= 1'b0;
      rem_neg_q    <= 1'b0;
      div0_q       <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      case (state_q)
        StIdle: begin
          if (valid) begin
            case (func_code)
              FnMfhi: begin
                result       <= hi;
                result_valid <= 1'b1;
              end
              FnMflo: begin
                result       <= lo;
                result_valid <= 1'b1;
              end
              FnMthi: hi <= op_a;
              FnMtlo: lo <= op_a;
              FnMult, FnMultu: begin
                state_q  <= StMul;
                busy     <= 1'b1;
                is_mul_q <= 1'b1;
                acc_q    <= {{WIDTH{1'b0}}, mag_b};
                opnd_q   <= mag_a;
                neg_q    <= fn_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                cnt_q    <= '0;
              end
              FnDiv, FnDivu: begin
                state_q    <= StDiv;
                busy       <= 1'b1;
                is_mul_q   <= 1'b0;
                acc_q      <= {{WIDTH{1'b0}}, mag_a};
                opnd_q     <= mag_b;
                neg_q      <= fn_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                rem_neg_q  <= fn_signed & op_a[WIDTH-1];
                div0_q     <= (op_b == '0);
                dividend_q <= op_a;
                cnt_q      <= '0;
              end
              default: ;
            endcase
          end
        end
        StMul: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_q <= StFix;
            // done is shown during FIX, the same cycle HI/LO are being written.
            done    <= 1'b1;
          end
        end
        StDiv: begin
          acc_q <= {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_q <= StFix;
            done    <= 1'b1;
          end
        end
        StFix: begin
          if (is_mul_q) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div0_q) begin
            // Divide by zero: all-ones quotient, dividend left in HI untouched.
            hi <= dividend_q;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
